// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared widths, register index type and writeback source encoding.
package rf_wb_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef logic [AW-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_LL   = 2'd2
    } wb_src_e;
endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// rf_scoreboard: per-register busy/kill tracking of outstanding long-latency destinations.
// Register 0 never becomes busy or killed.
module rf_scoreboard
    import rf_wb_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            issue,
    input  reg_idx_t        issue_rd,
    input  logic            clr,
    input  reg_idx_t        clr_rd,
    input  logic            wr,
    input  reg_idx_t        wr_rd,
    input  reg_idx_t        rs1,
    input  reg_idx_t        rs2,
    output logic [NREG-1:0] busy,
    output logic [NREG-1:0] kill,
    output logic            rs1_busy,
    output logic            rs2_busy
);
    logic [NREG-1:0] busy_q, kill_q, busy_d, kill_d;

    always_comb begin
        busy_d = busy_q;
        kill_d = kill_q;
        for (int r = 1; r < NREG; r++) begin
            if (issue && issue_rd == reg_idx_t'(r)) begin
                busy_d[r] = 1'b1;
                kill_d[r] = 1'b0;
            end else if (clr && clr_rd == reg_idx_t'(r)) begin
                busy_d[r] = 1'b0;
                kill_d[r] = 1'b0;
            end else if (wr && wr_rd == reg_idx_t'(r) && busy_q[r]) begin
                kill_d[r] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
        kill_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            kill_q <= '0;
        end else begin
            busy_q <= busy_d;
            kill_q <= kill_d;
        end
    end

    assign busy     = busy_q;
    assign kill     = kill_q;
    assign rs1_busy = busy_q[rs1] & ~kill_q[rs1];
    assign rs2_busy = busy_q[rs2] & ~kill_q[rs2];
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: owns the register file write port, merging pipeline WB and long-latency results.
// Optional same-cycle forwarding of the granted write is enabled by defining RF_WB_BYPASS_EN.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wb_valid,
    input  reg_idx_t        wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ll_issue,
    input  reg_idx_t        ll_issue_rd,
    input  logic            ll_valid,
    input  reg_idx_t        ll_rd,
    input  logic [XLEN-1:0] ll_data,
    output logic            ll_ready,
    input  reg_idx_t        rs1,
    input  reg_idx_t        rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            wb_hold,
    output logic            rf_we,
    output reg_idx_t        rf_addr_d,
    output logic [XLEN-1:0] rf_data_d,
`ifdef RF_WB_BYPASS_EN
    output logic            rs1_fwd,
    output logic            rs2_fwd,
    output logic [XLEN-1:0] fwd_data1,
    output logic [XLEN-1:0] fwd_data2,
`endif
    output logic [NREG-1:0] busy_vec
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    wb_src_e         src;
    logic            hs, stall;
    logic [NREG-1:0] kill_vec;
    logic            sb_rs1_busy, sb_rs2_busy;
    logic [CW-1:0]   cnt_q, cnt_d;

    assign src       = wb_valid ? SRC_WB : ll_valid ? SRC_LL : SRC_NONE;
    assign ll_ready  = reset_n & ~wb_valid;
    assign hs        = ll_valid & ll_ready;
    assign stall     = ll_valid & ~ll_ready;
    assign rf_addr_d = src == SRC_WB ? wb_rd : src == SRC_LL ? ll_rd : '0;
    assign rf_data_d = src == SRC_WB ? wb_data : src == SRC_LL ? ll_data : '0;
    // A killed LL result still completes its handshake but must not clobber the younger WB value.
    assign rf_we     = reset_n & (src != SRC_NONE) & (rf_addr_d != '0)
                     & ~(src == SRC_LL & kill_vec[ll_rd]);

    rf_scoreboard u_sb (
        .clk      (clk),
        .reset_n  (reset_n),
        .issue    (ll_issue),
        .issue_rd (ll_issue_rd),
        .clr      (hs),
        .clr_rd   (ll_rd),
        .wr       (wb_valid & (wb_rd != '0)),
        .wr_rd    (wb_rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .busy     (busy_vec),
        .kill     (kill_vec),
        .rs1_busy (sb_rs1_busy),
        .rs2_busy (sb_rs2_busy)
    );

`ifdef RF_WB_BYPASS_EN
    logic ll_wr;
    assign ll_wr     = rf_we & (src == SRC_LL);
    assign rs1_fwd   = rf_we & (rf_addr_d == rs1);
    assign rs2_fwd   = rf_we & (rf_addr_d == rs2);
    assign fwd_data1 = rf_data_d;
    assign fwd_data2 = rf_data_d;
    assign rs1_busy  = sb_rs1_busy & ~(ll_wr & (ll_rd == rs1));
    assign rs2_busy  = sb_rs2_busy & ~(ll_wr & (ll_rd == rs2));
`else
    assign rs1_busy  = sb_rs1_busy;
    assign rs2_busy  = sb_rs2_busy;
`endif

    assign cnt_d = !stall ? '0 : cnt_q == CW'(STARVE_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            wb_hold <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            wb_hold <= cnt_d == CW'(STARVE_MAX);
        end
    end

    // Reissue to a register is legal only when its pending result completes in the same cycle.
    a_issue_free: assert property (@(posedge clk) disable iff (!reset_n)
        ll_issue |-> (!busy_vec[ll_issue_rd] || (hs && ll_rd == ll_issue_rd)));
    a_no_wb_on_hold: assert property (@(posedge clk) disable iff (!reset_n)
        wb_valid |-> !wb_hold);
    a_ll_dest_live: assert property (@(posedge clk) disable iff (!reset_n)
        hs |-> (busy_vec[ll_rd] && ll_rd != '0));
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed checks of grant, scoreboard, WAW drop, starvation hold, x0 and reset.
module tb_rf_wb_arbiter;
    import rf_wb_pkg::*;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic            wb_valid = 1'b0, ll_issue = 1'b0, ll_valid = 1'b0;
    reg_idx_t        wb_rd = '0, ll_issue_rd = '0, ll_rd = '0, rs1 = '0, rs2 = '0;
    logic [XLEN-1:0] wb_data = '0, ll_data = '0;
    logic            ll_ready, rs1_busy, rs2_busy, wb_hold, rf_we;
    reg_idx_t        rf_addr_d;
    logic [XLEN-1:0] rf_data_d;
    logic [NREG-1:0] busy_vec;
`ifdef RF_WB_BYPASS_EN
    logic            rs1_fwd, rs2_fwd;
    logic [XLEN-1:0] fwd_data1, fwd_data2;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .ll_issue(ll_issue), .ll_issue_rd(ll_issue_rd),
        .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wb_hold(wb_hold), .rf_we(rf_we), .rf_addr_d(rf_addr_d), .rf_data_d(rf_data_d),
`ifdef RF_WB_BYPASS_EN
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
        .busy_vec(busy_vec)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        nxt(); nxt();
        #2;
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_ll_ready", 32'(ll_ready), 0);
        chk("rst_busy_vec", busy_vec, 0);
        chk("rst_wb_hold", 32'(wb_hold), 0);
        nxt();
        reset_n = 1'b1;

        // WB write is granted with zero latency
        wb_valid = 1; wb_rd = 5; wb_data = 32'hA5;
        #2;
        chk("t1_rf_we", 32'(rf_we), 1);
        chk("t1_addr", 32'(rf_addr_d), 5);
        chk("t1_data", rf_data_d, 32'hA5);
        chk("t1_ll_ready", 32'(ll_ready), 0);
        nxt();

        // LL issue, hazard, completion
        wb_valid = 0; ll_issue = 1; ll_issue_rd = 7;
        #2 chk("t2_idle_we", 32'(rf_we), 0);
        nxt();
        ll_issue = 0; rs1 = 7;
        #2;
        chk("t2_rs1_busy", 32'(rs1_busy), 1);
        chk("t2_busy_vec", busy_vec, 32'h80);
        nxt();
        ll_valid = 1; ll_rd = 7; ll_data = 32'h1234;
        #2;
        chk("t2_ll_ready", 32'(ll_ready), 1);
        chk("t2_rf_we", 32'(rf_we), 1);
        chk("t2_addr", 32'(rf_addr_d), 7);
        chk("t2_data", rf_data_d, 32'h1234);
`ifdef RF_WB_BYPASS_EN
        chk("t2_rs1_busy_byp", 32'(rs1_busy), 0);
        chk("t2_rs1_fwd", 32'(rs1_fwd), 1);
        chk("t2_fwd_data1", fwd_data1, 32'h1234);
`else
        chk("t2_rs1_busy_same", 32'(rs1_busy), 1);
`endif
        nxt();
        ll_valid = 0;
        #2;
        chk("t2_busy_clr", busy_vec, 0);
        chk("t2_rs1_free", 32'(rs1_busy), 0);
        nxt();

        // WAW: younger WB write kills the pending LL result
        ll_issue = 1; ll_issue_rd = 9;
        nxt();
        ll_issue = 0; wb_valid = 1; wb_rd = 9; wb_data = 32'h11;
        #2;
        chk("t3_wb_we", 32'(rf_we), 1);
        chk("t3_wb_data", rf_data_d, 32'h11);
        nxt();
        wb_valid = 0; rs1 = 9;
        #2;
        chk("t3_rs1_killed", 32'(rs1_busy), 0);
        chk("t3_busy_vec", busy_vec, 32'h200);
        ll_valid = 1; ll_rd = 9; ll_data = 32'h22;
        #1;
        chk("t3_ll_ready", 32'(ll_ready), 1);
        chk("t3_rf_we", 32'(rf_we), 0);
        nxt();
        ll_valid = 0;
        #2 chk("t3_busy_clr", busy_vec, 0);
        nxt();

        // Starvation: four stalled cycles raise wb_hold
        ll_issue = 1; ll_issue_rd = 4;
        nxt();
        ll_issue = 0; ll_valid = 1; ll_rd = 4; ll_data = 32'h44;
        wb_valid = 1; wb_rd = 10; wb_data = 32'h10;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("t4_hold_low", 32'(wb_hold), 0);
            chk("t4_wb_granted", 32'(rf_addr_d), 10);
            nxt();
        end
        #2 chk("t4_hold_high", 32'(wb_hold), 1);
        wb_valid = 0;
        #1;
        chk("t4_ll_ready", 32'(ll_ready), 1);
        chk("t4_ll_we", 32'(rf_we), 1);
        chk("t4_ll_addr", 32'(rf_addr_d), 4);
        nxt();
        ll_valid = 0;
        #2;
        chk("t4_hold_drop", 32'(wb_hold), 0);
        chk("t4_busy_clr", busy_vec, 0);
        nxt();

        // x0 never written nor tracked
        wb_valid = 1; wb_rd = 0; wb_data = 32'hFF; ll_issue = 1; ll_issue_rd = 0;
        #2 chk("t5_x0_we", 32'(rf_we), 0);
        nxt();
        wb_valid = 0; ll_issue = 1; ll_issue_rd = 3;
        #2 chk("t5_x0_busy", busy_vec, 0);
        nxt();
        ll_valid = 1; ll_rd = 3; ll_data = 32'h33;
        #2 chk("t5_complete_we", 32'(rf_we), 1);
        nxt();
        ll_issue = 0; ll_valid = 0; rs2 = 3;
        #2;
        chk("t5_issue_wins", busy_vec, 32'h8);
        chk("t5_rs2_busy", 32'(rs2_busy), 1);

        // Async reset mid-stall
        ll_issue = 1; ll_issue_rd = 9;
        nxt();
        ll_issue = 0; ll_valid = 1; ll_rd = 3; wb_valid = 1; wb_rd = 12;
        nxt(); nxt();
        #2;
        chk("t6_busy_pre", busy_vec, 32'h208);
        chk("t6_hold_pre", 32'(wb_hold), 0);
        reset_n = 0;
        #1;
        chk("t6_busy_rst", busy_vec, 0);
        chk("t6_hold_rst", 32'(wb_hold), 0);
        chk("t6_we_rst", 32'(rf_we), 0);
        chk("t6_ready_rst", 32'(ll_ready), 0);
        wb_valid = 0; ll_valid = 0;
        nxt();
        reset_n = 1;
        nxt();
        #2 chk("t6_post_busy", busy_vec, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
